// File: rtl/frame_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_streamer_pkg
//  Description : Shared game package. Default screen geometry, pixel format
//                and the frame streamer state encoding, used by the render
//                and display blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_streamer_pkg;

    localparam int c_DEF_SCREEN_WIDTH  = 30;
    localparam int c_DEF_SCREEN_HEIGHT = 30;
    localparam int c_DEF_PIXEL_BITS    = 24;  // r[23:16] g[15:8] b[7:0]

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_STREAM = 2'd1;
    localparam state_t c_ST_DONE   = 2'd2;

    // Index width for a range of n values; never narrower than one bit
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_streamer_pixel_cursor.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_cursor
//  Description : Raster x/y cursor (x inner, y outer) with frame position
//                flags for the frame streamer.
//  Ports       : clk, reset      - clock / synchronous active-high reset
//                clear           - return cursor to (0,0)
//                advance         - step cursor one pixel in raster order
//                x, y            - current coordinates
//                sof, eol, eof   - first pixel / last of row / last of frame
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_cursor
    import frame_streamer_pkg::*;
#(
    parameter int WIDTH  = c_DEF_SCREEN_WIDTH,
    parameter int HEIGHT = c_DEF_SCREEN_HEIGHT,
    localparam int XW    = idxWidth(WIDTH),
    localparam int YW    = idxWidth(HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          eof
);

    localparam logic [XW-1:0] c_X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (advance) begin
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                // Wrap y too so the cursor rests at (0,0) after the last pixel
                r_y <= (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign x   = r_x;
    assign y   = r_y;
    assign sof = (r_x == '0) && (r_y == '0);
    assign eol = (r_x == c_X_LAST);
    assign eof = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

endmodule
`default_nettype wire

// File: rtl/frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_streamer
//  Description : Snapshots a rendered frame on request and streams it out in
//                raster order over a valid/ready pixel interface. One request
//                may be queued while a frame is in flight.
//  Ports       : clk, reset            - clock / synchronous active-high reset
//                screen                - rendered frame, element x*H+y
//                frame_req             - request to stream one frame
//                pix_valid/ready/data  - pixel beat handshake
//                pix_x, pix_y          - coordinates of current beat
//                sof, eol, eof         - beat position flags (valid-qualified)
//                busy                  - streaming or finishing a frame
//                frame_done            - one-cycle pulse after last beat
//                frame_count           - completed frames, wraps at 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int SCREEN_WIDTH  = c_DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = c_DEF_SCREEN_HEIGHT,
    parameter int PIXEL_BITS    = c_DEF_PIXEL_BITS,
    localparam int XW           = idxWidth(SCREEN_WIDTH),
    localparam int YW           = idxWidth(SCREEN_HEIGHT)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [SCREEN_WIDTH*SCREEN_HEIGHT*PIXEL_BITS-1:0] screen,
    input  logic                                        frame_req,
    output logic                                        pix_valid,
    input  logic                                        pix_ready,
    output logic [PIXEL_BITS-1:0]                       pix_data,
    output logic [XW-1:0]                               pix_x,
    output logic [YW-1:0]                               pix_y,
    output logic                                        sof,
    output logic                                        eol,
    output logic                                        eof,
    output logic                                        busy,
    output logic                                        frame_done,
    output logic [15:0]                                 frame_count
);

    localparam int c_NPIX = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int c_IW   = idxWidth(c_NPIX);

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_pending;
    logic [15:0]           r_frameCount;
    logic [PIXEL_BITS-1:0] r_frameBuf [c_NPIX];

    logic                  w_snapshot;
    logic                  w_transfer;
    logic [XW-1:0]         w_curX;
    logic [YW-1:0]         w_curY;
    logic                  w_curSof;
    logic                  w_curEol;
    logic                  w_curEof;
    logic [c_IW-1:0]       w_pixIdx;

    assign w_transfer = pix_valid && pix_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_nextState;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_nextState = r_state;
        w_snapshot  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (frame_req) begin
                    w_nextState = c_ST_STREAM;
                    w_snapshot  = 1'b1;
                end
            end
            c_ST_STREAM: begin
                if (w_transfer && w_curEof) w_nextState = c_ST_DONE;
            end
            c_ST_DONE: begin
                // A request arriving in DONE itself is treated as pending
                if (r_pending || frame_req) begin
                    w_nextState = c_ST_STREAM;
                    w_snapshot  = 1'b1;
                end else begin
                    w_nextState = c_ST_IDLE;
                end
            end
            default: w_nextState = c_ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        pix_valid  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            c_ST_STREAM: begin
                pix_valid = 1'b1;
                busy      = 1'b1;
            end
            c_ST_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end

    // One-deep request queue; consumed (or discarded) on leaving DONE
    always_ff @(posedge clk) begin
        if (reset)                                     r_pending <= 1'b0;
        else if (r_state == c_ST_DONE)                 r_pending <= 1'b0;
        else if (r_state == c_ST_STREAM && frame_req)  r_pending <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)                      r_frameCount <= '0;
        else if (r_state == c_ST_DONE)  r_frameCount <= r_frameCount + 16'd1;
    end

    // Frame buffer is deliberately not reset; it is always written before use
    always_ff @(posedge clk) begin
        if (w_snapshot) begin
            for (int i = 0; i < c_NPIX; i++) begin
                r_frameBuf[i] <= screen[i*PIXEL_BITS +: PIXEL_BITS];
            end
        end
    end

    pixel_cursor #(
        .WIDTH  (SCREEN_WIDTH),
        .HEIGHT (SCREEN_HEIGHT)
    ) u_cursor (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_snapshot),
        .advance (w_transfer),
        .x       (w_curX),
        .y       (w_curY),
        .sof     (w_curSof),
        .eol     (w_curEol),
        .eof     (w_curEof)
    );

    // Column-major storage: element index is x*HEIGHT + y
    assign w_pixIdx = c_IW'(w_curX) * c_IW'(SCREEN_HEIGHT) + c_IW'(w_curY);

    assign pix_data    = pix_valid ? r_frameBuf[w_pixIdx] : '0;
    assign pix_x       = w_curX;
    assign pix_y       = w_curY;
    assign sof         = pix_valid && w_curSof;
    assign eol         = pix_valid && w_curEol;
    assign eof         = pix_valid && w_curEof;
    assign frame_count = r_frameCount;

endmodule
`default_nettype wire

// File: tb/tb_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_streamer
//  Description : Self-checking bench for frame_streamer. Expected beats are
//                queued when a frame is requested and compared as the DUT
//                transfers them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_streamer;

    localparam int W  = 30;
    localparam int H  = 30;
    localparam int PB = 24;
    localparam int NP = W * H;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NP*PB-1:0] screen = '0;
    logic             frame_req = 1'b0;
    logic             pix_ready = 1'b1;
    logic             pix_valid;
    logic [PB-1:0]    pix_data;
    logic [4:0]       pix_x;
    logic [4:0]       pix_y;
    logic             sof, eol, eof, busy, frame_done;
    logic [15:0]      frame_count;

    frame_streamer #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .PIXEL_BITS    (PB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .screen      (screen),
        .frame_req   (frame_req),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .sof         (sof),
        .eol         (eol),
        .eof         (eof),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [PB-1:0] model [NP];
    logic [36:0]   sbq [$];   // {data, x, y, sof, eol, eof}

    int   beats = 0, nzCnt = 0, nzBeat = -1, eofCnt = 0, eofBeat = -1;
    int   doneCount = 0;
    logic stallPend = 1'b0;
    logic [37:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic failNow(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyModel();
        for (int i = 0; i < NP; i++) screen[i*PB +: PB] = model[i];
    endtask

    task automatic pushFrame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                sbq.push_back({model[x*H+y], 5'(x), 5'(y),
                               1'(x == 0 && y == 0), 1'(x == W-1),
                               1'(x == W-1 && y == H-1)});
    endtask

    task automatic startFrame();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int bound, output int at);
        int n = 0;
        while (!frame_done && n < bound) begin
            tick();
            n++;
        end
        if (!frame_done) failNow(tag);
        at = cyc;
    endtask

    task automatic clearStats();
        beats = 0; nzCnt = 0; nzBeat = -1; eofCnt = 0; eofBeat = -1;
    endtask

    // Monitor: compares every transferred beat and holds outputs during stalls
    always @(negedge clk) begin
        if (reset) begin
            stallPend = 1'b0;
        end else begin
            if (stallPend)
                check("stall_hold", {pix_valid, pix_data, pix_x, pix_y, sof, eol, eof}, held);
            if (pix_valid && pix_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL sb_underflow observed=beat(%0d,%0d) expected=no_beat", pix_x, pix_y);
                end else begin
                    check("beat", {pix_data, pix_x, pix_y, sof, eol, eof}, sbq.pop_front());
                end
                if (pix_data != '0) begin nzCnt++; nzBeat = beats; end
                if (eof) begin eofCnt++; eofBeat = beats; end
                beats++;
            end
            stallPend = pix_valid && !pix_ready;
            held      = {pix_valid, pix_data, pix_x, pix_y, sof, eol, eof};
            if (frame_done) doneCount++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, at, d0, busyLow, n;

        // ---------------- reset state ----------------
        reset = 1'b1;
        repeat (3) tick();
        check("rst_valid", pix_valid, 1'b0);
        check("rst_data", pix_data, 24'h0);
        check("rst_xy", {pix_x, pix_y}, 10'h0);
        check("rst_flags", {sof, eol, eof}, 3'b000);
        check("rst_busy_done", {busy, frame_done}, 2'b00);
        check("rst_count", frame_count, 16'd0);
        reset = 1'b0;
        tick();

        // ---------------- A: single red pixel, ready held high ----------------
        for (int i = 0; i < NP; i++) model[i] = '0;
        model[3*H+2] = 24'hFF0000;
        applyModel();
        clearStats();
        pushFrame();
        startFrame();
        t0 = cyc;
        check("a_first_valid", {pix_valid, sof, busy}, 3'b111);
        waitDone("a_wait_done", 2000, at);
        check("a_done_latency", at - t0, 900);
        tick();
        check("a_count", frame_count, 16'd1);
        check("a_idle", {busy, pix_valid, frame_done}, 3'b000);
        check("a_beats", beats, 900);
        check("a_red_beat", {nzCnt[7:0], nzBeat[15:0]}, {8'd1, 16'd63});
        check("a_eof", {eofCnt[7:0], eofBeat[15:0]}, {8'd1, 16'd899});
        check("a_done_pulses", doneCount, 1);
        check("a_sb_empty", sbq.size(), 0);

        // ---------------- B: ready pattern 1,0,0 ----------------
        for (int i = 0; i < NP; i++) model[i] = 24'($urandom);
        applyModel();
        clearStats();
        pushFrame();
        startFrame();
        n = 0;
        while (!frame_done && n < 5000) begin
            pix_ready = (n % 3 == 0);
            tick();
            n++;
        end
        if (!frame_done) failNow("b_wait_done");
        pix_ready = 1'b1;
        tick();
        check("b_count", frame_count, 16'd2);
        check("b_beats", beats, 900);
        check("b_eof", {eofCnt[7:0], eofBeat[15:0]}, {8'd1, 16'd899});
        check("b_sb_empty", sbq.size(), 0);

        // ---------------- C: screen overwritten mid-frame ----------------
        for (int i = 0; i < NP; i++) model[i] = 24'($urandom);
        applyModel();
        clearStats();
        pushFrame();
        startFrame();
        n = 0;
        while (beats < 10 && n < 100) begin tick(); n++; end
        for (int i = 0; i < NP; i++) screen[i*PB +: PB] = 24'h00FF00;
        waitDone("c_wait_done", 2000, at);
        tick();
        check("c_count", frame_count, 16'd3);
        check("c_beats", beats, 900);
        check("c_sb_empty", sbq.size(), 0);

        // ---------------- D: three requests while streaming ----------------
        applyModel();
        clearStats();
        d0 = doneCount;
        pushFrame();
        startFrame();
        repeat (5) tick();
        pushFrame();
        for (int k = 0; k < 3; k++) begin
            frame_req = 1'b1;
            tick();
            frame_req = 1'b0;
            repeat (7) tick();
        end
        busyLow = 0;
        n = 0;
        while (doneCount < d0 + 2 && n < 4000) begin
            if (!busy) busyLow++;
            tick();
            n++;
        end
        if (doneCount < d0 + 2) failNow("d_wait_done");
        repeat (3) tick();
        check("d_done_pulses", doneCount - d0, 2);
        check("d_busy_gaps", busyLow, 0);
        check("d_count", frame_count, 16'd5);
        check("d_no_third", {busy, pix_valid}, 2'b00);
        check("d_beats", beats, 1800);
        check("d_eofs", eofCnt, 2);
        check("d_sb_empty", sbq.size(), 0);

        // ---------------- E: reset mid-frame ----------------
        clearStats();
        pushFrame();
        startFrame();
        n = 0;
        while (beats < 450 && n < 2000) begin tick(); n++; end
        if (beats < 450) failNow("e_wait_450");
        reset     = 1'b1;
        frame_req = 1'b1;
        tick();
        check("e_rst_outputs", {pix_valid, pix_data, pix_x, pix_y, sof, eol, eof, busy, frame_done},
              36'h0);
        check("e_rst_count", frame_count, 16'd0);
        tick();
        reset     = 1'b0;
        frame_req = 1'b0;
        sbq.delete();
        d0 = doneCount;
        repeat (20) tick();
        check("e_no_done", doneCount - d0, 0);
        check("e_count_zero", frame_count, 16'd0);
        check("e_idle", {busy, pix_valid}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
